// File: rtl/spc700_addw_seq_pkg.sv
// Shared encodings for the SPC700 16-bit word arithmetic sequencer.
package spc700_addw_seq_pkg;

  localparam logic [1:0] ADDW_OP = 2'd0;
  localparam logic [1:0] SUBW_OP = 2'd1;
  localparam logic [1:0] CMPW_OP = 2'd2;
  localparam logic [1:0] RSVD_OP = 2'd3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLo   = 2'd1,
    StHi   = 2'd2
  } state_e;

  typedef struct packed {
    logic n;
    logic v;
    logic h;
    logic z;
    logic c;
  } flags_t;

endpackage

// File: rtl/spc700_addw_seq_if.sv
// Request/result bundle between the microcode sequencer and the word-op unit.
interface spc700_addw_seq_if;

  logic        EN;
  logic        START;
  logic [1:0]  OP;
  logic [15:0] YA;
  logic [15:0] M;
  logic        BUSY;
  logic        DONE;
  logic [15:0] RESULT;
  logic        WR_RES;
  logic        NVH_UPD;
  logic        N_OUT;
  logic        V_OUT;
  logic        H_OUT;
  logic        Z_OUT;
  logic        C_OUT;

  modport master (
    output EN, START, OP, YA, M,
    input  BUSY, DONE, RESULT, WR_RES, NVH_UPD, N_OUT, V_OUT, H_OUT, Z_OUT, C_OUT
  );

  modport slave (
    input  EN, START, OP, YA, M,
    output BUSY, DONE, RESULT, WR_RES, NVH_UPD, N_OUT, V_OUT, H_OUT, Z_OUT, C_OUT
  );

endinterface

// File: rtl/spc700_addw_seq_addsub.sv
// SPC700 8-bit adder/subtractor: S = A + (ADD ? B : ~B) + CI, with carry, half-carry
// and signed overflow.
module spc700_addw_seq_addsub (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       ci_i,
  input  logic       add_i,
  output logic [7:0] s_o,
  output logic       co_o,
  output logic       vo_o,
  output logic       ho_o
);

  logic [7:0] b_eff;
  logic [8:0] sum9;
  logic [4:0] sum5;

  always_comb begin
    b_eff = add_i ? b_i : ~b_i;
    sum9  = {1'b0, a_i} + {1'b0, b_eff} + {8'd0, ci_i};
    sum5  = {1'b0, a_i[3:0]} + {1'b0, b_eff[3:0]} + {4'd0, ci_i};
    s_o   = sum9[7:0];
    co_o  = sum9[8];
    ho_o  = sum5[4];
    // Overflow when both effective operands share a sign the result does not.
    vo_o  = (a_i[7] == b_eff[7]) && (sum9[7] != a_i[7]);
  end

endmodule

// File: rtl/spc700_addw_seq.sv
// Word ADDW/SUBW/CMPW sequencer: two passes through one 8-bit adder (low byte,
// then high byte with chained carry), then registered result and flags.
module spc700_addw_seq
  import spc700_addw_seq_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  spc700_addw_seq_if.slave   bus
);

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [15:0] ya_q, ya_d;
  logic [15:0] m_q, m_d;
  logic [7:0]  lo_sum_q, lo_sum_d;
  logic        lo_c_q, lo_c_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        wr_res_q, wr_res_d;
  logic        nvh_upd_q, nvh_upd_d;
  flags_t      flags_q, flags_d;

  logic [7:0]  add_a, add_b, add_s;
  logic        add_ci, add_add, add_co, add_vo, add_ho;

  // Adder inputs are steered by state; IDLE parks it on 0 + 0.
  always_comb begin
    add_a   = 8'h00;
    add_b   = 8'h00;
    add_ci  = 1'b0;
    add_add = 1'b1;
    unique case (state_q)
      StLo: begin
        add_a   = ya_q[7:0];
        add_b   = m_q[7:0];
        add_add = (op_q == ADDW_OP);
        add_ci  = (op_q != ADDW_OP);
      end
      StHi: begin
        add_a   = ya_q[15:8];
        add_b   = m_q[15:8];
        add_add = (op_q == ADDW_OP);
        add_ci  = lo_c_q;
      end
      default: ;
    endcase
  end

  spc700_addw_seq_addsub u_addsub (
    .a_i   (add_a),
    .b_i   (add_b),
    .ci_i  (add_ci),
    .add_i (add_add),
    .s_o   (add_s),
    .co_o  (add_co),
    .vo_o  (add_vo),
    .ho_o  (add_ho)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ya_d      = ya_q;
    m_d       = m_q;
    lo_sum_d  = lo_sum_q;
    lo_c_d    = lo_c_q;
    busy_d    = busy_q;
    done_d    = done_q;
    result_d  = result_q;
    wr_res_d  = wr_res_q;
    nvh_upd_d = nvh_upd_q;
    flags_d   = flags_q;
    if (bus.EN) begin
      done_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.START && (bus.OP != RSVD_OP)) begin
            op_d    = bus.OP;
            ya_d    = bus.YA;
            m_d     = bus.M;
            busy_d  = 1'b1;
            state_d = StLo;
          end
        end
        StLo: begin
          lo_sum_d = add_s;
          lo_c_d   = add_co;
          state_d  = StHi;
        end
        StHi: begin
          result_d  = {add_s, lo_sum_q};
          flags_d.n = add_s[7];
          flags_d.v = add_vo;
          flags_d.h = add_ho;
          flags_d.z = ({add_s, lo_sum_q} == 16'h0000);
          flags_d.c = add_co;
          wr_res_d  = (op_q != CMPW_OP);
          nvh_upd_d = (op_q != CMPW_OP);
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = StIdle;
        end
        default: begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      op_q      <= 2'd0;
      ya_q      <= 16'h0000;
      m_q       <= 16'h0000;
      lo_sum_q  <= 8'h00;
      lo_c_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 16'h0000;
      wr_res_q  <= 1'b0;
      nvh_upd_q <= 1'b0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ya_q      <= ya_d;
      m_q       <= m_d;
      lo_sum_q  <= lo_sum_d;
      lo_c_q    <= lo_c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      wr_res_q  <= wr_res_d;
      nvh_upd_q <= nvh_upd_d;
      flags_q   <= flags_d;
    end
  end

  assign bus.BUSY    = busy_q;
  assign bus.DONE    = done_q;
  assign bus.RESULT  = result_q;
  assign bus.WR_RES  = wr_res_q;
  assign bus.NVH_UPD = nvh_upd_q;
  assign bus.N_OUT   = flags_q.n;
  assign bus.V_OUT   = flags_q.v;
  assign bus.H_OUT   = flags_q.h;
  assign bus.Z_OUT   = flags_q.z;
  assign bus.C_OUT   = flags_q.c;

endmodule
